register_bank: RTL and testbench
================================

# register_bank

Parametrised register bank for the multicycle processor datapath, generalising the single 16-bit bus-loaded register into NUM_REGS registers of DATA_WIDTH bits. It provides one write port loaded from `buswire` and two combinational read ports. One register is designated as the program counter and has its own increment path. A one-level undo restores the value a register held before its most recent write. It sits between the control unit and the shared bus/ALU.

## Interface
- DATA_WIDTH, 16, bit width of each register and of the bus.
- NUM_REGS, 8, number of registers; must be ≥ 2. ADDR_WIDTH = $clog2(NUM_REGS) is derived internally.
- PC_INDEX, NUM_REGS-1, index of the register with the increment path.
- RESET_VALUE, 0, value every register takes on reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- buswire  in  DATA_WIDTH  write data.
- wren  in  1  write enable.
- wr_addr  in  ADDR_WIDTH  write target.
- incr_pc  in  1  increment register PC_INDEX.
- undo  in  1  restore the last written register.
- rd_addr_a, rd_addr_b  in  ADDR_WIDTH  read selects.
- rd_data_a, rd_data_b  out  DATA_WIDTH  combinational read data.
- pc_out  out  DATA_WIDTH  current value of register PC_INDEX.
- hist_valid  out  1  an undo is available.

## Operation
- State: the register array, plus a history entry {hist_valid, hist_addr, hist_value}.
- Write (wren=1):
  - reg[wr_addr] <= buswire.
  - The history captures hist_addr <= wr_addr and hist_value <= the old reg[wr_addr], and sets hist_valid <= 1.
  - A write with buswire equal to the old value still records history.
- Increment (incr_pc=1): reg[PC_INDEX] <= reg[PC_INDEX] + 1, modulo 2^DATA_WIDTH. All-ones wraps to 0. Increments never touch history.
- Undo (undo=1, hist_valid=1): reg[hist_addr] <= hist_value and hist_valid <= 0. Undo with hist_valid=0 is a no-op. Only one level of history is kept.
- Priority when events coincide in one cycle:
  - wren beats undo: the write happens, undo is ignored, and history is overwritten by the new write.
  - A write to PC_INDEX beats incr_pc: the increment is dropped.
  - An undo targeting PC_INDEX beats incr_pc.
  - A write to another register and incr_pc both take effect.
  - An undo targeting a register other than PC_INDEX and incr_pc both take effect.
- Reads: rd_data_x = reg[rd_addr_x], purely combinational. There is no write-through bypass: a read in the write cycle returns the old value. rd_addr ≥ NUM_REGS (non-power-of-2 depth) returns 0.
- Writes with wr_addr ≥ NUM_REGS are ignored and do not update history.

## Timing
- All state updates occur on the rising edge of clock.
- Write-to-read latency is 1 cycle: the new value is visible on the read ports after the edge.
- pc_out and hist_valid are direct register outputs with no combinational input path.
- Reset:
  - Asynchronous assertion: every register becomes RESET_VALUE and hist_valid, hist_addr and hist_value become 0 immediately, with no clock required.
  - Consequently rd_data_a, rd_data_b and pc_out equal RESET_VALUE while reset is high.
  - Reset dominates wren, incr_pc and undo. Reset in the middle of any sequence discards pending history.
  - Release is synchronous-safe: the first operation is taken at the first rising edge after reset falls.

## Test plan
- Reset then read: assert reset with no clock edge → all reads and pc_out = 0, hist_valid = 0. Release, then wren=1, wr_addr=1, buswire=0x0007, one edge → rd_data_a (addr 1) = 0x0007, hist_valid = 1.
- Two ports, no bypass: write 0x0002 to R0, then 0x0007 to R1. In the same cycle as the R1 write, rd_addr_b = 1 reads 0 (old value). On the next cycle, A=R0 reads 0x0002 and B=R1 reads 0x0007.
- PC increment and wrap: write 0xFFFE to R7, then incr_pc for 3 cycles → pc_out goes 0xFFFF, 0x0000, 0x0001. hist_valid stays at 1 from the write, and hist_value = 0.
- Write vs increment: R7 = 0x0010, then wren to R7 with 0x0100 and incr_pc=1 in the same cycle → pc_out = 0x0100. Write to R2 together with incr_pc → R2 updated and pc_out = 0x0101.
- Undo:
  - R3 = 0x00AA, then write 0x0055 to R3, then undo → R3 = 0x00AA and hist_valid = 0.
  - A second undo is a no-op.
  - undo together with wren to R3 with 0x0011 → R3 = 0x0011, and a following undo restores 0x00AA.
- Reset mid-operation: after several writes, pulse reset between clock edges → state clears asynchronously, and an undo after release does nothing.

Source files
------------

// File: rtl/register_bank.sv
// Register bank for the multicycle datapath: one bus-loaded write port, two
// combinational read ports, a program-counter increment path and a one-level undo.
module register_bank #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    NUM_REGS    = 8,
  parameter int                    PC_INDEX    = NUM_REGS - 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                   ADDR_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] buswire,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  incr_pc,
  input  logic                  undo,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  hist_valid
);

  // One extra bit so that NUM_REGS itself is representable for range checks.
  localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR    = PC_INDEX[ADDR_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  hist_valid_q, hist_valid_d;
  logic [ADDR_WIDTH-1:0] hist_addr_q,  hist_addr_d;
  logic [DATA_WIDTH-1:0] hist_value_q, hist_value_d;

  logic wr_ok;
  logic undo_ok;
  logic incr_ok;

  function automatic logic [DATA_WIDTH-1:0] pc_increment(input logic [DATA_WIDTH-1:0] v);
    return v + DATA_WIDTH'(1);
  endfunction

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  always_comb begin
    wr_ok   = wren && addr_in_range(wr_addr);
    undo_ok = undo && hist_valid_q && !wr_ok;
    // A write or undo landing on the PC owns that register this cycle.
    incr_ok = incr_pc
              && !(wr_ok && (wr_addr == PC_ADDR))
              && !(undo_ok && (hist_addr_q == PC_ADDR));
  end

  always_comb begin
    regs_d       = regs_q;
    hist_valid_d = hist_valid_q;
    hist_addr_d  = hist_addr_q;
    hist_value_d = hist_value_q;

    if (incr_ok) begin
      regs_d[PC_INDEX] = pc_increment(regs_q[PC_INDEX]);
    end

    if (wr_ok) begin
      regs_d[wr_addr] = buswire;
      hist_valid_d    = 1'b1;
      hist_addr_d     = wr_addr;
      hist_value_d    = regs_q[wr_addr];
    end else if (undo_ok) begin
      regs_d[hist_addr_q] = hist_value_q;
      hist_valid_d        = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
      hist_valid_q <= 1'b0;
      hist_addr_q  <= '0;
      hist_value_q <= '0;
    end else begin
      regs_q       <= regs_d;
      hist_valid_q <= hist_valid_d;
      hist_addr_q  <= hist_addr_d;
      hist_value_q <= hist_value_d;
    end
  end

  // Reads see only registered state: no bypass from the write port.
  assign rd_data_a  = addr_in_range(rd_addr_a) ? regs_q[rd_addr_a] : '0;
  assign rd_data_b  = addr_in_range(rd_addr_b) ? regs_q[rd_addr_b] : '0;
  assign pc_out     = regs_q[PC_INDEX];
  assign hist_valid = hist_valid_q;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed vector table, hand-written
// reset/bypass sequences, and randomized traffic against a behavioural model.
module tb_register_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] buswire = '0;
  logic        wren = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic        incr_pc = 1'b0;
  logic        undo = 1'b0;
  logic [2:0]  rd_addr_a = '0;
  logic [2:0]  rd_addr_b = '0;
  logic [15:0] rd_data_a, rd_data_b, pc_out;
  logic        hist_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the architectural state.
  logic [15:0] m_reg [8];
  bit          m_hv;
  int          m_ha;
  logic [15:0] m_hval;

  register_bank dut (
    .clock(clock), .reset(reset), .buswire(buswire), .wren(wren),
    .wr_addr(wr_addr), .incr_pc(incr_pc), .undo(undo),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .pc_out(pc_out), .hist_valid(hist_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit        w;
    bit [2:0]  a;
    bit [15:0] d;
    bit        inc;
    bit        u;
    bit [2:0]  ra;
    bit [2:0]  rb;
    bit [15:0] ea;
    bit [15:0] eb;
    bit [15:0] epc;
    bit        ehv;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    m_hv = 0; m_ha = 0; m_hval = 16'h0000;
  endtask

  task automatic model_step(input bit w, input int a, input logic [15:0] d,
                            input bit inc, input bit u);
    int pc_owner;
    pc_owner = -1;
    if (w) begin
      m_hval = m_reg[a]; m_ha = a; m_hv = 1;
      m_reg[a] = d;
      pc_owner = a;
    end else if (u && m_hv) begin
      m_reg[m_ha] = m_hval;
      m_hv = 0;
      pc_owner = m_ha;
    end
    if (inc && pc_owner != 7) m_reg[7] = m_reg[7] + 16'd1;
  endtask

  // Called just after a rising edge; drives one cycle and returns just after the next edge.
  task automatic cyc(input bit w, input bit [2:0] a, input bit [15:0] d,
                     input bit inc, input bit u, input bit [2:0] ra, input bit [2:0] rb);
    wren = w; wr_addr = a; buswire = d; incr_pc = inc; undo = u;
    rd_addr_a = ra; rd_addr_b = rb;
    @(posedge clock);
    #1;
    model_step(w, int'(a), d, inc, u);
    wren = 0; incr_pc = 0; undo = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_rda"}, rd_data_a, m_reg[rd_addr_a]);
    chk({tag, "_rdb"}, rd_data_b, m_reg[rd_addr_b]);
    chk({tag, "_pc"}, pc_out, m_reg[7]);
    chk({tag, "_hv"}, hist_valid, m_hv);
  endtask

  initial begin
    //        w  a  data     inc u  ra rb  ea       eb       epc      ehv
    vecs[0]  = '{1, 1, 16'h0007, 0, 0, 1, 0, 16'h0007, 16'h0000, 16'h0000, 1};
    vecs[1]  = '{1, 0, 16'h0002, 0, 0, 0, 1, 16'h0002, 16'h0007, 16'h0000, 1};
    vecs[2]  = '{1, 7, 16'hFFFE, 0, 0, 7, 0, 16'hFFFE, 16'h0002, 16'hFFFE, 1};
    vecs[3]  = '{0, 0, 16'h0000, 1, 0, 7, 1, 16'hFFFF, 16'h0007, 16'hFFFF, 1};
    vecs[4]  = '{0, 0, 16'h0000, 1, 0, 7, 1, 16'h0000, 16'h0007, 16'h0000, 1};
    vecs[5]  = '{0, 0, 16'h0000, 1, 0, 7, 1, 16'h0001, 16'h0007, 16'h0001, 1};
    vecs[6]  = '{0, 0, 16'h0000, 0, 1, 7, 0, 16'h0000, 16'h0002, 16'h0000, 0};
    vecs[7]  = '{1, 7, 16'h0010, 0, 0, 7, 0, 16'h0010, 16'h0002, 16'h0010, 1};
    vecs[8]  = '{1, 7, 16'h0100, 1, 0, 7, 0, 16'h0100, 16'h0002, 16'h0100, 1};
    vecs[9]  = '{1, 2, 16'h0ABC, 1, 0, 2, 7, 16'h0ABC, 16'h0101, 16'h0101, 1};
    vecs[10] = '{1, 3, 16'h00AA, 0, 0, 3, 2, 16'h00AA, 16'h0ABC, 16'h0101, 1};
    vecs[11] = '{1, 3, 16'h0055, 0, 0, 3, 2, 16'h0055, 16'h0ABC, 16'h0101, 1};
    vecs[12] = '{0, 0, 16'h0000, 0, 1, 3, 2, 16'h00AA, 16'h0ABC, 16'h0101, 0};
    vecs[13] = '{0, 0, 16'h0000, 0, 1, 3, 2, 16'h00AA, 16'h0ABC, 16'h0101, 0};
    vecs[14] = '{1, 3, 16'h0011, 0, 1, 3, 2, 16'h0011, 16'h0ABC, 16'h0101, 1};
    vecs[15] = '{0, 0, 16'h0000, 0, 1, 3, 2, 16'h00AA, 16'h0ABC, 16'h0101, 0};
    vecs[16] = '{1, 5, 16'h5555, 0, 0, 5, 7, 16'h5555, 16'h0101, 16'h0101, 1};
    vecs[17] = '{0, 0, 16'h0000, 1, 1, 5, 7, 16'h0000, 16'h0102, 16'h0102, 0};
    vecs[18] = '{1, 7, 16'h2000, 1, 0, 7, 5, 16'h2000, 16'h0000, 16'h2000, 1};
    vecs[19] = '{0, 0, 16'h0000, 1, 1, 7, 3, 16'h0102, 16'h00AA, 16'h0102, 0};

    // Asynchronous reset with no clock edge in between.
    #1 reset = 1;
    model_reset();
    #1;
    for (int i = 0; i < 8; i += 2) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(i + 1);
      #0.1;
      chk("rst_rda", rd_data_a, 16'h0000);
      chk("rst_rdb", rd_data_b, 16'h0000);
    end
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_hv", hist_valid, 1'b0);
    #1 reset = 0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].inc, vecs[i].u, vecs[i].ra, vecs[i].rb);
      chk($sformatf("vec%0d_rda", i), rd_data_a, vecs[i].ea);
      chk($sformatf("vec%0d_rdb", i), rd_data_b, vecs[i].eb);
      chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].epc);
      chk($sformatf("vec%0d_hv", i), hist_valid, vecs[i].ehv);
    end

    // Reset pulsed between edges clears state immediately; a later undo does nothing.
    cyc(1, 4, 16'hBEEF, 0, 0, 4, 7);
    chk("pre_rst_r4", rd_data_a, 16'hBEEF);
    reset = 1;
    #1;
    chk("midrst_rda", rd_data_a, 16'h0000);
    chk("midrst_pc", pc_out, 16'h0000);
    chk("midrst_hv", hist_valid, 1'b0);
    #1 reset = 0;
    model_reset();
    cyc(0, 0, 16'h0000, 0, 1, 4, 3);
    chk("post_rst_undo_r4", rd_data_a, 16'h0000);
    chk("post_rst_undo_r3", rd_data_b, 16'h0000);
    chk("post_rst_undo_hv", hist_valid, 1'b0);

    // No write-through bypass: read in the write cycle sees the old value.
    cyc(1, 0, 16'h0002, 0, 0, 0, 1);
    wren = 1; wr_addr = 3'd1; buswire = 16'h0007; rd_addr_a = 3'd0; rd_addr_b = 3'd1;
    #2;
    chk("nobypass_rdb", rd_data_b, 16'h0000);
    cyc(1, 1, 16'h0007, 0, 0, 0, 1);
    chk("after_wr_rda", rd_data_a, 16'h0002);
    chk("after_wr_rdb", rd_data_b, 16'h0007);

    // Randomized traffic against the model, with PC writes biased near wrap.
    for (int n = 0; n < 400; n++) begin
      bit        w, inc, u;
      bit [2:0]  a, ra, rb;
      bit [15:0] d;
      w   = ($urandom_range(0, 99) < 45);
      a   = 3'($urandom_range(0, 7));
      d   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFD, 16'hFFFF)) : 16'($urandom);
      inc = ($urandom_range(0, 99) < 50);
      u   = ($urandom_range(0, 99) < 35);
      ra  = 3'($urandom_range(0, 7));
      rb  = 3'($urandom_range(0, 7));
      cyc(w, a, d, inc, u, ra, rb);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
